// File: rtl/road_obstacle_spawner.sv
// road_obstacle_spawner: consumer of the road random-number generator.
// Counts frame ticks, requests a fresh random value every SPAWN_PERIOD
// ticks, rejects out-of-range values (bounded retries, then a mid-lane
// fallback), and offers the resulting X coordinate over valid/ack.
// Ports:
//   clk, resetN    - clock, asynchronous active-low reset
//   enable         - game running; low aborts to IDLE
//   startOfFrame   - one-cycle frame tick
//   rand_in[5:0]   - generator dout
//   spawn_ack      - obstacle logic accepted spawn_x
//   rand_req       - generator rise input (registered)
//   spawn_valid    - spawn_x valid, held until ack
//   spawn_x[10:0]  - obstacle X coordinate
//   busy           - high whenever not IDLE
//   missed_count   - saturating count of dropped triggers
module road_obstacle_spawner #(
  parameter int unsigned SPAWN_PERIOD = 30,
  parameter int unsigned LANE_MIN_X   = 200,
  parameter int unsigned LANE_STEP    = 4,
  parameter int unsigned MAX_RAND     = 59,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic        startOfFrame,
  input  logic [5:0]  rand_in,
  input  logic        spawn_ack,
  output logic        rand_req,
  output logic        spawn_valid,
  output logic [10:0] spawn_x,
  output logic        busy,
  output logic [7:0]  missed_count
);

  localparam int unsigned CNT_W   = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
  localparam int unsigned RAND_W  = 6;
  localparam int unsigned X_W     = 11;
  localparam int unsigned MISS_W  = 8;
  localparam logic [X_W-1:0] FALLBACK_X = X_W'(LANE_MIN_X + (MAX_RAND / 2) * LANE_STEP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SAMPLE,
    ST_OFFER
  } state_t;

  state_t              r_state,       w_state_nxt;
  logic [CNT_W-1:0]    r_frame_cnt,   w_frame_cnt_nxt;
  logic                r_pending,     w_pending_nxt;
  logic [RETRY_W-1:0]  r_retry,       w_retry_nxt;
  logic [RAND_W-1:0]   r_rand,        w_rand_nxt;
  logic                r_rand_req,    w_rand_req_nxt;
  logic                r_spawn_valid, w_spawn_valid_nxt;
  logic [X_W-1:0]      r_spawn_x,     w_spawn_x_nxt;
  logic                r_busy,        w_busy_nxt;
  logic [MISS_W-1:0]   r_missed,      w_missed_nxt;

  logic w_period_end;
  logic w_trigger;

  assign w_period_end = (r_frame_cnt == CNT_W'(SPAWN_PERIOD - 1));
  assign w_trigger    = enable && startOfFrame && w_period_end;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_pending_nxt   = r_pending;
    w_retry_nxt     = r_retry;
    w_rand_nxt      = r_rand;
    w_spawn_x_nxt   = r_spawn_x;
    w_missed_nxt    = r_missed;

    if (enable && startOfFrame) begin
      w_frame_cnt_nxt = w_period_end ? '0 : r_frame_cnt + CNT_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        if (w_trigger || r_pending) begin
          w_state_nxt   = ST_REQ;
          w_pending_nxt = 1'b0;
          w_retry_nxt   = '0;
        end
      end
      ST_REQ:  w_state_nxt = ST_WAIT;
      // Guarantees the generator sees rise low before any later request
      ST_WAIT: w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: begin
        w_rand_nxt = rand_in;
        if (rand_in <= RAND_W'(MAX_RAND)) begin
          w_state_nxt   = ST_OFFER;
          w_spawn_x_nxt = X_W'(LANE_MIN_X) + X_W'(rand_in) * X_W'(LANE_STEP);
        end else if (r_retry < RETRY_W'(MAX_RETRY)) begin
          w_state_nxt = ST_REQ;
          w_retry_nxt = r_retry + RETRY_W'(1);
        end else begin
          // Retries exhausted: fall back to the middle of the legal range
          w_state_nxt   = ST_OFFER;
          w_rand_nxt    = RAND_W'(MAX_RAND / 2);
          w_spawn_x_nxt = FALLBACK_X;
        end
      end
      ST_OFFER: begin
        if (spawn_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Triggers while busy: first one is remembered, further ones are counted
    if (w_trigger && (r_state != ST_IDLE)) begin
      if (!r_pending) begin
        w_pending_nxt = 1'b1;
      end else if (r_missed != '1) begin
        w_missed_nxt = r_missed + MISS_W'(1);
      end
    end

    if (!enable) begin
      w_state_nxt     = ST_IDLE;
      w_frame_cnt_nxt = '0;
      w_pending_nxt   = 1'b0;
      w_retry_nxt     = '0;
    end

    w_rand_req_nxt    = (w_state_nxt == ST_REQ);
    w_spawn_valid_nxt = (w_state_nxt == ST_OFFER);
    w_busy_nxt        = (w_state_nxt != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_IDLE;
      r_frame_cnt   <= '0;
      r_pending     <= 1'b0;
      r_retry       <= '0;
      r_rand        <= '0;
      r_rand_req    <= 1'b0;
      r_spawn_valid <= 1'b0;
      r_spawn_x     <= '0;
      r_busy        <= 1'b0;
      r_missed      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_pending     <= w_pending_nxt;
      r_retry       <= w_retry_nxt;
      r_rand        <= w_rand_nxt;
      r_rand_req    <= w_rand_req_nxt;
      r_spawn_valid <= w_spawn_valid_nxt;
      r_spawn_x     <= w_spawn_x_nxt;
      r_busy        <= w_busy_nxt;
      r_missed      <= w_missed_nxt;
    end
  end

  assign rand_req     = r_rand_req;
  assign spawn_valid  = r_spawn_valid;
  assign spawn_x      = r_spawn_x;
  assign busy         = r_busy;
  assign missed_count = r_missed;

endmodule

// File: doc/road_obstacle_spawner.md
# road_obstacle_spawner

Consumer side of the road random-number generator. Periodically requests a fresh random value by driving a clean rising edge on the generator's `rise` input. It then samples the generator's 6-bit output, rejects values outside the legal lane range, and converts the accepted value to a screen X coordinate. Finally, it offers that coordinate to the obstacle-object logic through a valid/ack handshake.

## Interface
- SPAWN_PERIOD, 30: number of startOfFrame ticks between spawn triggers (≥1)
- LANE_MIN_X, 200: X pixel of random value 0
- LANE_STEP, 4: pixels per random unit
- MAX_RAND, 59: largest accepted random value; larger values are rejected
- MAX_RETRY, 3: rejections tolerated before fallback
- Constraint: LANE_MIN_X + MAX_RAND*LANE_STEP ≤ 639
- clk  input  1  system clock
- resetN  input  1  reset, asynchronous, active-low
- enable  input  1  game running; low aborts and idles the block
- startOfFrame  input  1  one-cycle frame tick
- rand_in  input  6  unsigned random value from the generator's dout
- spawn_ack  input  1  obstacle logic accepted spawn_x
- rand_req  output  1  drives the generator's rise input; registered
- spawn_valid  output  1  spawn_x is valid; held until ack
- spawn_x  output  11  unsigned obstacle X coordinate
- busy  output  1  high in every state except IDLE
- missed_count  output  8  saturating count of dropped triggers

## Operation
- FSM states: IDLE, REQ, WAIT, SAMPLE, OFFER.
- **Frame counter** (0..SPAWN_PERIOD-1):
  - Counts startOfFrame ticks while enable=1.
  - A tick at count SPAWN_PERIOD-1 produces a trigger and wraps the counter to 0.
- **IDLE**:
  - Moves to REQ on a trigger or when pending=1.
  - Clears pending and the retry counter on that transition.
- **REQ**: rand_req=1 for exactly one cycle, then → WAIT.
- **WAIT**: rand_req=0 for one cycle, so the generator sees a fresh low before any later edge. Then → SAMPLE.
- **SAMPLE**: registers r = rand_in and decides as follows.
  - If r ≤ MAX_RAND: accept r and go to OFFER.
  - If r > MAX_RAND and retry < MAX_RETRY: increment retry and go to REQ.
  - Otherwise: use r = MAX_RAND/2 (integer division) and go to OFFER.
- **OFFER**:
  - spawn_x = LANE_MIN_X + r*LANE_STEP, computed at 11-bit width with no truncation under the stated constraint.
  - spawn_valid=1 with spawn_x stable.
  - On spawn_ack=1: → IDLE, with spawn_valid low from the next cycle.
- **Trigger arriving while busy**:
  - If pending=0: set pending=1.
  - If pending=1: increment missed_count, saturating at 255.
  - A trigger in OFFER on the same cycle as spawn_ack also takes this path, so it sets pending.
- **enable=0 in any state**:
  - Next state is IDLE; rand_req=0 and spawn_valid=0.
  - Frame counter, pending and retry are cleared; missed_count is held.
- **Reset values**:
  - All outputs = 0.
  - State IDLE; frame counter, pending, retry and r are 0.

## Timing
- rand_req first rises 1 cycle after the trigger cycle (the cycle startOfFrame is sampled in IDLE).
- rand_in is sampled 2 cycles after rand_req rises. This covers the generator's one-cycle capture latency: the generator updates dout on the edge where it first sees rise=1.
- **Spawn latency**: spawn_valid rises 4 cycles after the trigger cycle when there are no retries. Each retry adds 3 cycles.
- The earliest next request is 1 cycle after the ack cycle (IDLE with pending=1). rand_req is therefore never high on two consecutive cycles, and is always low for at least 2 cycles between requests.
- spawn_x is registered and changes only on entry to OFFER.
- A reset asserted mid-operation forces the reset values asynchronously. No handshake survives a reset.

## Test plan
- **Basic spawn**:
  - Stimulus: defaults, enable=1, 30 ticks, generator returning 10.
  - Required: one rand_req pulse; spawn_valid 4 cycles after the 30th tick; spawn_x=240; ack drops valid the next cycle.
- **Retry then accept**:
  - Stimulus: generator returns 63, then 61, then 5.
  - Required: three rand_req pulses, each separated by 3 cycles; spawn_x=220.
- **Fallback**:
  - Stimulus: generator returns 63 on 4 consecutive requests.
  - Required: exactly 4 rand_req pulses; spawn_x=316 (r=29).
- **Backpressure**:
  - Stimulus: SPAWN_PERIOD=1, spawn_ack held low for 5 ticks.
  - Required: pending set by the first tick while busy; missed_count=3 or more, matching the extra ticks; immediate REQ after ack.
- **Abort**:
  - Stimulus: enable dropped during WAIT, and separately during OFFER.
  - Required: IDLE next cycle, spawn_valid=0, rand_req=0; frame counter restarts at 0 after re-enable.
- **Reset mid-OFFER**:
  - Stimulus: resetN pulsed while spawn_valid=1.
  - Required: all outputs 0 immediately; missed_count=0; normal spawn after release.
